shift_seq_ctrl: RTL

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle logical shifter: shifts by up to two bit positions per cycle, then
// presents the result on dout with a one-cycle done pulse.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Shift candidates for the current accumulator in the latched direction.
    logic [WIDTH-1:0] acc_sh1, acc_sh2;

    always_comb begin
        acc_sh1 = dir_q ? (acc_q >> 1) : (acc_q << 1);
        acc_sh2 = dir_q ? (acc_q >> 2) : (acc_q << 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        dout_d  = dout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = din;
                    cnt_d = shamt;
                    dir_d = dir;
                    if (shamt == '0) begin
                        state_d = ST_DONE;
                        dout_d  = din;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_q >= SHW'(2)) begin
                    acc_d = acc_sh2;
                    cnt_d = cnt_q - SHW'(2);
                end else if (cnt_q == SHW'(1)) begin
                    acc_d = acc_sh1;
                    cnt_d = '0;
                end
                // Finish on the step that exhausts the count (cnt_q==0 is unreachable here).
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                    dout_d  = acc_d;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the next-state decode.
        busy_d = (state_d == ST_SHIFT) || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule
